// File: rtl/ring_pkg.sv
// ---------------------------------------------------------------------------
// ring_pkg
// Shared definitions for the inter-router ring link.
//
// A ring packet is laid out MSB first as:
//   [48]    VALID
//   [47:32] timestamp
//   [31:16] source id
//   [15:0]  destination id
//
// The backpressure word returned upstream carries the OFF flag in bit 0
// and the number of free receive slots in bits [15:1].
// ---------------------------------------------------------------------------
package ring_pkg;

    // Default link width; modules take PACKET_SIZE as a parameter.
    localparam int DEFAULT_PACKET_SIZE = 49;

    // Packet field positions for the default link width.
    localparam int PKT_VALID_BIT   = DEFAULT_PACKET_SIZE - 1;
    localparam int TIMESTAMP_LSB   = 32;
    localparam int TIMESTAMP_WIDTH = 16;
    localparam int SRC_LSB         = 16;
    localparam int SRC_WIDTH       = 16;
    localparam int DST_LSB         = 0;
    localparam int DST_WIDTH       = 16;

    // Backpressure word layout.
    localparam int BP_OFF_BIT  = 0;
    localparam int BP_FREE_MAX = 32767;

    typedef logic [DEFAULT_PACKET_SIZE-1:0] packet_t;
    typedef logic [15:0]                    bp_word_t;

    // On/off flow-control state signalled to the upstream transmitter.
    typedef enum logic [0:0] {
        BP_ON  = 1'b0,
        BP_OFF = 1'b1
    } bp_state_e;

    // The free-slot field is only 15 bits wide, so deep buffers report
    // the largest representable value instead of wrapping.
    function automatic logic [14:0] sat_free(input int unsigned free_slots);
        logic [31:0] w_val;
        w_val = free_slots;
        if (free_slots > BP_FREE_MAX) begin
            return 15'h7FFF;
        end
        return w_val[14:0];
    endfunction

endpackage

// File: rtl/ring_link_rx_if.sv
// ---------------------------------------------------------------------------
// ring_link_rx_if
// Bundle of the receive-side link and switch handshake signals.
//
//   link_in          packet from the upstream transmitter
//   backpressure_wr  on/off + free-slot word returned upstream
//   pkt_out          FIFO head packet towards the switch
//   pkt_valid        head packet valid
//   pkt_ready        switch accepts the head packet
//
// slave  : the receiver (ring_link_rx)
// master : the environment (upstream transmitter and switch)
// ---------------------------------------------------------------------------
interface ring_link_rx_if #(
    parameter int PACKET_SIZE = ring_pkg::DEFAULT_PACKET_SIZE
);

    logic [PACKET_SIZE-1:0] link_in;
    logic [15:0]            backpressure_wr;
    logic [PACKET_SIZE-1:0] pkt_out;
    logic                   pkt_valid;
    logic                   pkt_ready;

    modport slave (
        input  link_in,
        input  pkt_ready,
        output backpressure_wr,
        output pkt_out,
        output pkt_valid
    );

    modport master (
        output link_in,
        output pkt_ready,
        input  backpressure_wr,
        input  pkt_out,
        input  pkt_valid
    );

endinterface

// File: rtl/ring_fifo.sv
// ---------------------------------------------------------------------------
// ring_fifo
// Plain first-word-fall-through FIFO with an arbitrary (not necessarily
// power-of-two) depth. It knows nothing about packets or flow control; the
// caller must never push when full unless it pops in the same cycle, and
// must never pop when empty.
//
// Ports:
//   clk      clock
//   rst      synchronous active-high reset (empties the FIFO)
//   i_push   write i_data at the write pointer
//   i_pop    release the head entry
//   i_data   data to write
//   o_data   head entry, zero while empty
//   o_count  current occupancy, 0..DEPTH
//   o_full   occupancy == DEPTH
//   o_empty  occupancy == 0
// ---------------------------------------------------------------------------
module ring_fifo #(
    parameter int WIDTH = 49,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_data,
    output logic [WIDTH-1:0]             o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wrPtr;
    logic [PW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;

    // Pointers wrap explicitly at DEPTH-1 so any depth works.
    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
        if (ptr == PW'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PW'(1);
    endfunction

    // Storage array: written only on push, never reset, because the
    // occupancy count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping. A simultaneous push and pop
    // leaves the count unchanged while both pointers advance, which is
    // how a full FIFO reuses the slot freed by the pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wrPtr <= nextPtr(r_wrPtr);
            end
            if (i_pop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!i_push && i_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Head is read combinationally; it is forced to zero while empty so
    // stale or uninitialised memory never shows up on the output.
    always_comb begin
        o_data = '0;
        if (r_count != '0) begin
            o_data = r_mem[r_rdPtr];
        end
    end

    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/ring_link_rx.sv
// ---------------------------------------------------------------------------
// ring_link_rx
// Receive end of one ring link direction. Incoming packets with VALID set
// are buffered in a BUFFER_SIZE-deep FIFO and offered to the router switch
// with a valid/ready handshake. The upstream transmitter is throttled by a
// registered on/off word with hysteresis; packets that still arrive while
// the FIFO is full (and not draining) are dropped and flagged.
//
// Parameter constraints: 2 <= BUFFER_SIZE <= 65535,
// OFF_THRESHOLD <= BUFFER_SIZE-2, ON_THRESHOLD < OFF_THRESHOLD.
// Keeping OFF two slots below full absorbs the two packets a compliant
// transmitter can still have in flight after it samples OFF.
//
// Ports:
//   clk                    clock
//   rst                    synchronous active-high reset
//   rx                     link/switch bundle (slave modport)
//   overflow               sticky: a valid packet was dropped
//   total_packet_accepted  64-bit count of packets written to the FIFO
//   total_packet_dropped   64-bit count of packets dropped
// ---------------------------------------------------------------------------
module ring_link_rx
    import ring_pkg::*;
#(
    parameter int PACKET_SIZE   = DEFAULT_PACKET_SIZE,
    parameter int BUFFER_SIZE   = 4,
    parameter int OFF_THRESHOLD = 2,
    parameter int ON_THRESHOLD  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    ring_link_rx_if.slave        rx,
    output logic                 overflow,
    output logic [63:0]          total_packet_accepted,
    output logic [63:0]          total_packet_dropped
);

    localparam int CW        = $clog2(BUFFER_SIZE + 1);
    localparam int VALID_BIT = PACKET_SIZE - 1;

    localparam logic [CW-1:0] OFF_LEVEL = CW'(OFF_THRESHOLD);
    localparam logic [CW-1:0] ON_LEVEL  = CW'(ON_THRESHOLD);

    logic [CW-1:0]  w_count;
    logic [CW-1:0]  w_occNext;
    logic           w_full;
    logic           w_empty;
    logic           w_present;
    logic           w_push;
    logic           w_pop;
    logic           w_drop;
    logic [14:0]    w_freeNext;
    bp_state_e      w_bpStateNext;
    bp_word_t       w_bpWord;

    bp_state_e      r_bpState;
    logic [14:0]    r_bpFree;
    logic           r_overflow;
    logic [63:0]    r_accepted;
    logic [63:0]    r_dropped;

    // A full FIFO can still take a packet when the switch pops in the
    // same cycle; only a valid arrival with no room at all is dropped.
    assign w_present = rx.link_in[VALID_BIT];
    assign w_pop     = !w_empty && rx.pkt_ready;
    assign w_push    = w_present && (!w_full || w_pop);
    assign w_drop    = w_present && w_full && !w_pop;

    ring_fifo #(
        .WIDTH (PACKET_SIZE),
        .DEPTH (BUFFER_SIZE)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (rx.link_in),
        .o_data  (rx.pkt_out),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign rx.pkt_valid = !w_empty;

    // Occupancy the FIFO will hold after this edge; the backpressure word
    // is derived from it so upstream sees the freshest possible state.
    always_comb begin
        w_occNext = w_count;
        if (w_push && !w_pop) begin
            w_occNext = w_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_occNext = w_count - CW'(1);
        end
    end

    // Hysteresis: OFF at or above the high mark, ON at or below the low
    // mark, otherwise keep signalling whatever was signalled last.
    always_comb begin
        w_bpStateNext = r_bpState;
        if (w_occNext >= OFF_LEVEL) begin
            w_bpStateNext = BP_OFF;
        end else if (w_occNext <= ON_LEVEL) begin
            w_bpStateNext = BP_ON;
        end
    end

    assign w_freeNext = sat_free(32'(BUFFER_SIZE) - 32'(w_occNext));

    // Flow-control state register and registered free-slot field.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bpState <= BP_ON;
            r_bpFree  <= sat_free(32'(BUFFER_SIZE));
        end else begin
            r_bpState <= w_bpStateNext;
            r_bpFree  <= w_freeNext;
        end
    end

    // Assemble the word sent upstream from the registered fields.
    always_comb begin
        w_bpWord             = '0;
        w_bpWord[15:1]       = r_bpFree;
        w_bpWord[BP_OFF_BIT] = (r_bpState == BP_OFF);
    end

    assign rx.backpressure_wr = w_bpWord;

    // Statistics: free-running 64-bit counters that wrap, and a drop flag
    // that stays set until the next reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_accepted <= '0;
            r_dropped  <= '0;
        end else begin
            if (w_push) begin
                r_accepted <= r_accepted + 64'd1;
            end
            if (w_drop) begin
                r_dropped  <= r_dropped + 64'd1;
                r_overflow <= 1'b1;
            end
        end
    end

    assign overflow              = r_overflow;
    assign total_packet_accepted = r_accepted;
    assign total_packet_dropped  = r_dropped;

endmodule

// File: tb/tb_ring_link_rx.sv
// ---------------------------------------------------------------------------
// tb_ring_link_rx
// Self-checking bench for ring_link_rx with default parameters. A queue
// based reference model tracks buffered packets, counters, the overflow
// flag and the on/off flag; every scenario task compares the DUT against
// it or against constants worked out from the flow-control rules.
// ---------------------------------------------------------------------------
module tb_ring_link_rx;

    localparam int PS  = 49;
    localparam int BUF = 4;
    localparam int OFF = 2;
    localparam int ON  = 1;

    logic        clk;
    logic        rst;
    logic        overflow;
    logic [63:0] total_packet_accepted;
    logic [63:0] total_packet_dropped;

    ring_link_rx_if #(.PACKET_SIZE(PS)) bus ();

    ring_link_rx #(
        .PACKET_SIZE   (PS),
        .BUFFER_SIZE   (BUF),
        .OFF_THRESHOLD (OFF),
        .ON_THRESHOLD  (ON)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .rx                    (bus),
        .overflow              (overflow),
        .total_packet_accepted (total_packet_accepted),
        .total_packet_dropped  (total_packet_dropped)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int nChecks = 0;
    int nErrors = 0;

    // Reference model state
    logic [PS-1:0] mq[$];
    logic [63:0]   mAcc;
    logic [63:0]   mDrop;
    logic          mOvf;
    logic          mOff;

    function automatic logic [PS-1:0] randPkt(input logic valid);
        return {valid, 16'($urandom), 16'($urandom), 16'($urandom)};
    endfunction

    function automatic logic [15:0] modelBp();
        return {15'(BUF - mq.size()), mOff};
    endfunction

    // Advance the model by one clock edge from the inputs seen at that edge.
    task automatic modelStep(input logic [PS-1:0] pkt, input logic ready, input logic rstIn);
        logic pop;
        logic push;
        int   occ;
        if (rstIn) begin
            mq.delete();
            mAcc  = '0;
            mDrop = '0;
            mOvf  = 1'b0;
            mOff  = 1'b0;
        end else begin
            pop  = (mq.size() != 0) && ready;
            push = pkt[PS-1] && ((mq.size() < BUF) || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(pkt);
                mAcc = mAcc + 64'd1;
            end
            if (pkt[PS-1] && !push) begin
                mDrop = mDrop + 64'd1;
                mOvf  = 1'b1;
            end
            occ = mq.size();
            if (occ >= OFF) mOff = 1'b1;
            else if (occ <= ON) mOff = 1'b0;
        end
    endtask

    // Drive inputs (called at a negedge), let one posedge pass, update the
    // model, and return at the next negedge where outputs are sampled.
    task automatic applyStimulus(input logic [PS-1:0] pkt, input logic ready, input logic rstIn);
        rst           = rstIn;
        bus.link_in   = pkt;
        bus.pkt_ready = ready;
        @(posedge clk);
        modelStep(pkt, ready, rstIn);
        @(negedge clk);
    endtask

    task automatic test_reset();
        applyStimulus('0, 1'b0, 1'b1);
        applyStimulus('0, 1'b0, 1'b1);
        nChecks++;
        if (bus.pkt_valid !== 1'b0) begin
            nErrors++;
            $display("[TB] FAIL reset_valid got %0b want 0", bus.pkt_valid);
        end
        nChecks++;
        if (bus.pkt_out !== '0) begin
            nErrors++;
            $display("[TB] FAIL reset_pkt_out got %h want 0", bus.pkt_out);
        end
        nChecks++;
        if (bus.backpressure_wr !== 16'h0008) begin
            nErrors++;
            $display("[TB] FAIL reset_bp got %h want 0008", bus.backpressure_wr);
        end
        nChecks++;
        if (overflow !== 1'b0 || total_packet_accepted !== 64'd0 || total_packet_dropped !== 64'd0) begin
            nErrors++;
            $display("[TB] FAIL reset_stats got ovf=%0b acc=%0d drop=%0d want 0/0/0",
                     overflow, total_packet_accepted, total_packet_dropped);
        end
        applyStimulus('0, 1'b0, 1'b0);
    endtask

    task automatic test_single_packet();
        logic [PS-1:0] pkt;
        pkt = {1'b1, 16'h0005, 16'h0001, 16'h0006};
        applyStimulus(pkt, 1'b1, 1'b0);
        nChecks++;
        if (bus.pkt_valid !== 1'b1 || bus.pkt_out !== pkt) begin
            nErrors++;
            $display("[TB] FAIL single_head got v=%0b %h want v=1 %h", bus.pkt_valid, bus.pkt_out, pkt);
        end
        nChecks++;
        if (bus.backpressure_wr !== 16'h0006) begin
            nErrors++;
            $display("[TB] FAIL single_bp_after_push got %h want 0006", bus.backpressure_wr);
        end
        applyStimulus('0, 1'b1, 1'b0);
        nChecks++;
        if (bus.pkt_valid !== 1'b0) begin
            nErrors++;
            $display("[TB] FAIL single_valid_one_cycle got %0b want 0", bus.pkt_valid);
        end
        nChecks++;
        if (total_packet_accepted !== 64'd1 || bus.backpressure_wr !== 16'h0008) begin
            nErrors++;
            $display("[TB] FAIL single_acc_bp got acc=%0d bp=%h want acc=1 bp=0008",
                     total_packet_accepted, bus.backpressure_wr);
        end
    endtask

    task automatic test_fill_and_drop();
        int            expFree[4] = '{3, 2, 1, 0};
        logic          expOff[4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [PS-1:0] first;
        logic [15:0]   want;
        first = randPkt(1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus((i == 0) ? first : randPkt(1'b1), 1'b0, 1'b0);
            want = {15'(expFree[i]), expOff[i]};
            nChecks++;
            if (bus.backpressure_wr !== want) begin
                nErrors++;
                $display("[TB] FAIL fill_bp[%0d] got %h want %h", i, bus.backpressure_wr, want);
            end
        end
        applyStimulus(randPkt(1'b1), 1'b0, 1'b0);
        nChecks++;
        if (total_packet_dropped !== 64'd1 || overflow !== 1'b1) begin
            nErrors++;
            $display("[TB] FAIL drop_stats got drop=%0d ovf=%0b want 1/1", total_packet_dropped, overflow);
        end
        nChecks++;
        if (bus.pkt_out !== first || bus.backpressure_wr !== 16'h0001) begin
            nErrors++;
            $display("[TB] FAIL drop_unchanged got %h bp=%h want %h bp=0001",
                     bus.pkt_out, bus.backpressure_wr, first);
        end
    endtask

    task automatic test_back_to_back();
        logic [PS-1:0] head;
        for (int i = 0; i < 10; i++) begin
            head = mq[0];
            nChecks++;
            if (bus.pkt_out !== head) begin
                nErrors++;
                $display("[TB] FAIL b2b_order[%0d] got %h want %h", i, bus.pkt_out, head);
            end
            applyStimulus(randPkt(1'b1), 1'b1, 1'b0);
            nChecks++;
            if (bus.backpressure_wr !== 16'h0001 || total_packet_dropped !== 64'd1) begin
                nErrors++;
                $display("[TB] FAIL b2b_full[%0d] got bp=%h drop=%0d want bp=0001 drop=1",
                         i, bus.backpressure_wr, total_packet_dropped);
            end
        end
        nChecks++;
        if (bus.pkt_out !== mq[0]) begin
            nErrors++;
            $display("[TB] FAIL b2b_final_head got %h want %h", bus.pkt_out, mq[0]);
        end
    endtask

    task automatic test_hysteresis();
        logic [15:0] expBp[5] = '{16'h0003, 16'h0005, 16'h0006, 16'h0005, 16'h0003};
        logic        ready[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        valid[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        // occupancy 4 -> 3 -> 2 -> 1 -> 2 -> 3
        for (int i = 0; i < 5; i++) begin
            applyStimulus(randPkt(valid[i]), ready[i], 1'b0);
            nChecks++;
            if (bus.backpressure_wr !== expBp[i] || bus.backpressure_wr !== modelBp()) begin
                nErrors++;
                $display("[TB] FAIL hyst_bp[%0d] got %h want %h", i, bus.backpressure_wr, expBp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        applyStimulus(randPkt(1'b1), 1'b0, 1'b1);
        nChecks++;
        if (bus.pkt_valid !== 1'b0 || bus.backpressure_wr !== 16'h0008) begin
            nErrors++;
            $display("[TB] FAIL midrst_out got v=%0b bp=%h want v=0 bp=0008", bus.pkt_valid, bus.backpressure_wr);
        end
        nChecks++;
        if (overflow !== 1'b0 || total_packet_accepted !== 64'd0 || total_packet_dropped !== 64'd0) begin
            nErrors++;
            $display("[TB] FAIL midrst_stats got ovf=%0b acc=%0d drop=%0d want 0/0/0",
                     overflow, total_packet_accepted, total_packet_dropped);
        end
        applyStimulus('0, 1'b0, 1'b0);
        nChecks++;
        if (bus.pkt_valid !== 1'b0) begin
            nErrors++;
            $display("[TB] FAIL midrst_not_stored got v=%0b want 0", bus.pkt_valid);
        end
    endtask

    task automatic test_invalid_stream();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(randPkt(1'b0), 1'($urandom), 1'b0);
            nChecks++;
            if (bus.pkt_valid !== 1'b0 || total_packet_accepted !== 64'd0) begin
                nErrors++;
                $display("[TB] FAIL invalid_ignored[%0d] got v=%0b acc=%0d want 0/0",
                         i, bus.pkt_valid, total_packet_accepted);
            end
        end
    endtask

    task automatic test_random();
        logic expValid;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(randPkt($urandom_range(0, 9) < 6), 1'($urandom), 1'b0);
            expValid = (mq.size() != 0);
            nChecks++;
            if (bus.pkt_valid !== expValid || (expValid && bus.pkt_out !== mq[0])) begin
                nErrors++;
                $display("[TB] FAIL rand_head[%0d] got v=%0b %h want v=%0b %h",
                         i, bus.pkt_valid, bus.pkt_out, expValid, expValid ? mq[0] : '0);
            end
            nChecks++;
            if (bus.backpressure_wr !== modelBp()) begin
                nErrors++;
                $display("[TB] FAIL rand_bp[%0d] got %h want %h", i, bus.backpressure_wr, modelBp());
            end
            nChecks++;
            if (total_packet_accepted !== mAcc || total_packet_dropped !== mDrop || overflow !== mOvf) begin
                nErrors++;
                $display("[TB] FAIL rand_stats[%0d] got acc=%0d drop=%0d ovf=%0b want %0d/%0d/%0b",
                         i, total_packet_accepted, total_packet_dropped, overflow, mAcc, mDrop, mOvf);
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.link_in   = '0;
        bus.pkt_ready = 1'b0;
        mAcc          = '0;
        mDrop         = '0;
        mOvf          = 1'b0;
        mOff          = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_packet();
        test_fill_and_drop();
        test_back_to_back();
        test_hysteresis();
        test_reset_mid();
        test_invalid_stream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
